// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
// Bundles the fetch stage's bus signals: hazard-unit controls, branch redirect,
// instruction-memory port, the IF/ID pipeline register outputs and the
// performance counters.
//   master : the environment side (hazard unit, branch resolution, imem, decode)
//   slave  : the fetch stage itself
// Signals:
//   PCWrite, IFIDWrite         hazard controls (0 = hold PC / hold IF/ID)
//   branch_taken, branch_target redirect request and address
//   imem_addr, imem_rdata      instruction memory address / combinational data
//   ifid_instr, ifid_pc4,
//   ifid_valid                 registered IF/ID contents
//   stall_cnt, flush_cnt       performance counters (0 when disabled)
// -----------------------------------------------------------------------------
interface fetch_stage_if;
  logic        PCWrite;
  logic        IFIDWrite;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  modport master (
    output PCWrite, IFIDWrite, branch_taken, branch_target, imem_rdata,
    input  imem_addr, ifid_instr, ifid_pc4, ifid_valid, stall_cnt, flush_cnt
  );

  modport slave (
    input  PCWrite, IFIDWrite, branch_taken, branch_target, imem_rdata,
    output imem_addr, ifid_instr, ifid_pc4, ifid_valid, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch stage: holds the PC, drives the instruction memory address
// straight from it, and captures the fetched word into the IF/ID register.
// Ports:
//   clk    : clock, all state changes on the rising edge
//   reset  : synchronous, active-high; loads RESET_PC and clears IF/ID/counters
//   bus    : fetch_stage_if.slave (controls, redirect, imem, IF/ID, counters)
// Parameter:
//   RESET_PC : PC value loaded on reset
// Build option:
//   FETCH_STAGE_PERF_CNT_EN : when defined, stall_cnt/flush_cnt are saturating
//   counters; otherwise both outputs are tied to zero and no counter flops exist.
// Priorities: reset > branch_taken > hold > advance/capture, evaluated
// separately for the PC and for the IF/ID register.
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.slave  bus
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;

  // Wraps modulo 2^32 by construction.
  assign pc_plus4 = pc_q + 32'd4;

  // Next-PC selection. Redirect targets are forced word aligned.
  always_comb begin
    pc_d = pc_q;
    if (bus.branch_taken) begin
      pc_d = {bus.branch_target[31:2], 2'b00};
    end else if (bus.PCWrite) begin
      pc_d = pc_plus4;
    end
  end

  // IF/ID next state. A redirect squashes the word fetched this cycle since
  // it came from the wrong path.
  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    if (bus.branch_taken) begin
      ifid_instr_d = 32'h0000_0000;
      ifid_pc4_d   = 32'h0000_0000;
      ifid_valid_d = 1'b0;
    end else if (bus.IFIDWrite) begin
      ifid_instr_d = bus.imem_rdata;
      ifid_pc4_d   = pc_plus4;
      ifid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      ifid_instr_q <= 32'h0000_0000;
      ifid_pc4_q   <= 32'h0000_0000;
      ifid_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign bus.imem_addr  = pc_q;
  assign bus.ifid_instr = ifid_instr_q;
  assign bus.ifid_pc4   = ifid_pc4_q;
  assign bus.ifid_valid = ifid_valid_q;

`ifdef FETCH_STAGE_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // A redirect cycle is counted as a flush only, never as a stall.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.branch_taken) begin
      if (flush_cnt_q != 32'hFFFF_FFFF) flush_cnt_d = flush_cnt_q + 32'd1;
    end else if (!bus.PCWrite) begin
      if (stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'h0000_0000;
      flush_cnt_q <= 32'h0000_0000;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`else
  assign bus.stall_cnt = 32'h0000_0000;
  assign bus.flush_cnt = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Directed scenarios followed by randomized control sequences for fetch_stage.
// Expected values come from a transaction-level model: a PC value, a 3-field
// IF/ID record and two counters, updated once per clock from the fetch rules.
// Instruction memory is a pure function of the address.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk;
  logic reset;
  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign bus.imem_rdata = mem_word(bus.imem_addr);

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pc4, m_stall, m_flush;
  logic        m_valid;
  bit          cnt_en;

  int total = 0;
  int bad   = 0;
  int txn   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Apply one cycle of inputs, advance the model by one edge, then compare.
  task automatic step(input bit rst, input bit pcw, input bit ifw,
                      input bit bt, input logic [31:0] tgt);
    logic [31:0] old_pc;
    @(negedge clk);
    reset             = rst;
    bus.PCWrite       = pcw;
    bus.IFIDWrite     = ifw;
    bus.branch_taken  = bt;
    bus.branch_target = tgt;
    old_pc = m_pc;
    if (rst) begin
      m_pc = RST_PC; m_instr = 0; m_pc4 = 0; m_valid = 0; m_stall = 0; m_flush = 0;
    end else if (bt) begin
      m_pc = tgt & 32'hFFFF_FFFC;
      m_instr = 0; m_pc4 = 0; m_valid = 0;
      m_flush = sat_inc(m_flush);
    end else begin
      if (pcw) m_pc = old_pc + 32'd4;
      else     m_stall = sat_inc(m_stall);
      if (ifw) begin
        m_instr = mem_word(old_pc); m_pc4 = old_pc + 32'd4; m_valid = 1;
      end
    end
    @(posedge clk);
    #1;
    txn++;
    $display("txn %0d rst=%0b pcw=%0b ifw=%0b bt=%0b tgt=%h -> pc=%h instr=%h pc4=%h v=%0b sc=%0d fc=%0d",
             txn, rst, pcw, ifw, bt, tgt, bus.imem_addr, bus.ifid_instr, bus.ifid_pc4,
             bus.ifid_valid, bus.stall_cnt, bus.flush_cnt);
    check("pc",        bus.imem_addr,          m_pc);
    check("ifid_instr", bus.ifid_instr,        m_instr);
    check("ifid_pc4",  bus.ifid_pc4,           m_pc4);
    check("ifid_valid", {31'd0, bus.ifid_valid}, {31'd0, m_valid});
    check("stall_cnt", bus.stall_cnt, cnt_en ? m_stall : 32'd0);
    check("flush_cnt", bus.flush_cnt, cnt_en ? m_flush : 32'd0);
  endtask

  initial begin
`ifdef FETCH_STAGE_PERF_CNT_EN
    cnt_en = 1'b1;
`else
    cnt_en = 1'b0;
`endif
    m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_stall = 0; m_flush = 0;
    reset = 1'b1; bus.PCWrite = 1'b1; bus.IFIDWrite = 1'b1;
    bus.branch_taken = 1'b0; bus.branch_target = 32'h0;

    // Reset for 3 cycles, then sequential fetch 0,4,8,...
    repeat (3) step(1, 1, 1, 0, 32'h0);
    check("rst_pc", bus.imem_addr, 32'h0);
    check("rst_valid", {31'd0, bus.ifid_valid}, 32'd0);
    step(0, 1, 1, 0, 32'h0);
    check("first_pc4", bus.ifid_pc4, 32'h4);
    check("first_instr", bus.ifid_instr, mem_word(32'h0));
    check("first_valid", {31'd0, bus.ifid_valid}, 32'd1);
    step(0, 1, 1, 0, 32'h0);
    check("pc_8", bus.imem_addr, 32'h8);
    step(0, 1, 1, 0, 32'h0);
    step(0, 1, 1, 0, 32'h0);
    check("pc_10", bus.imem_addr, 32'h10);

    // Two-cycle stall at 0x10, then resume
    step(0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 32'h0);
    check("stall_pc", bus.imem_addr, 32'h10);
    check("stall_cnt2", bus.stall_cnt, cnt_en ? 32'd2 : 32'd0);
    step(0, 1, 1, 0, 32'h0);
    check("resume_pc", bus.imem_addr, 32'h14);

    // Redirect with simultaneous stall; misaligned target
    step(0, 1, 1, 1, 32'h20);
    step(0, 0, 0, 1, 32'h103);
    check("redir_pc", bus.imem_addr, 32'h100);
    check("redir_valid", {31'd0, bus.ifid_valid}, 32'd0);
    check("redir_instr", bus.ifid_instr, 32'h0);
    step(0, 1, 1, 0, 32'h0);
    check("redir_pc4", bus.ifid_pc4, 32'h104);
    check("redir_valid2", {31'd0, bus.ifid_valid}, 32'd1);

    // PC wrap at top of address space
    step(0, 1, 1, 1, 32'hFFFF_FFFC);
    step(0, 1, 1, 0, 32'h0);
    check("wrap_pc", bus.imem_addr, 32'h0);
    check("wrap_pc4", bus.ifid_pc4, 32'h0);

    // Bubble held through IFIDWrite=0 while PC advances
    step(0, 1, 1, 1, 32'h40);
    step(0, 1, 0, 0, 32'h0);
    check("bubble_hold", {31'd0, bus.ifid_valid}, 32'd0);

    // Reset beats a simultaneous redirect
    step(1, 0, 1, 1, 32'h200);
    check("rst_bt_pc", bus.imem_addr, RST_PC);
    check("rst_bt_flush", bus.flush_cnt, 32'd0);

`ifdef FETCH_STAGE_PERF_CNT_EN
    // Preload stall counter near saturation, then stall past the limit
    step(0, 1, 1, 0, 32'h0);
    @(negedge clk);
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #1 release dut.stall_cnt_q;
    m_stall = 32'hFFFF_FFFD;
    repeat (4) step(0, 0, 1, 0, 32'h0);
    check("stall_sat", bus.stall_cnt, 32'hFFFF_FFFF);
`endif

    // Randomized control sequences
    for (int i = 0; i < 400; i++) begin
      bit r, pw, iw, b;
      r  = ($urandom_range(0, 39) == 0);
      pw = ($urandom_range(0, 3) != 0);
      iw = ($urandom_range(0, 3) != 0);
      b  = ($urandom_range(0, 7) == 0);
      step(r, pw, iw, b, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 PCWrite  input  1  from hazard unit; 0 = hold PC.
REQ-005 IFIDWrite  input  1  from hazard unit; 0 = hold IF/ID register.
REQ-006 branch_taken  input  1  redirect request, resolved downstream; also flushes IF/ID.
REQ-007 branch_target  input  32  redirect address.
REQ-008 imem_addr  output  32  instruction memory address (combinational = pc).
REQ-009 imem_rdata  input  32  instruction word, combinational read of imem_addr.
REQ-010 ifid_instr  output  32  registered instruction to decode.
REQ-011 ifid_pc4  output  32  registered pc+4 of that instruction.
REQ-012 ifid_valid  output  1  registered; 1 = ifid_instr is a real instruction.
REQ-013 stall_cnt  output  32  stall cycle counter (see Configuration).
REQ-014 flush_cnt  output  32  redirect counter (see Configuration).

Function
REQ-015 Internal pc register SHALL drive imem_addr directly; no extra latency.
REQ-016 pc+4 SHALL be 32-bit modulo; 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-017 Next-PC priority SHALL be: reset > branch_taken > PCWrite==0 (hold) > pc+4.
REQ-018 On branch_taken, pc SHALL load {branch_target[31:2],2'b00}; low two bits ignored.
REQ-019 branch_taken SHALL override PCWrite==0 and IFIDWrite==0 in the same cycle.
REQ-020 IF/ID priority SHALL be: reset > branch_taken (flush) > IFIDWrite==0 (hold) > capture.
REQ-021 Flush SHALL load ifid_instr=32'h0000_0000 (nop), ifid_pc4=0, ifid_valid=0.
REQ-022 Capture SHALL load ifid_instr=imem_rdata, ifid_pc4=pc+4, ifid_valid=1.
REQ-023 Hold SHALL keep ifid_instr, ifid_pc4, ifid_valid unchanged, including ifid_valid=0 bubbles.
REQ-024 PCWrite and IFIDWrite SHALL be handled independently; PCWrite=1 with IFIDWrite=0 advances pc while IF/ID holds (instruction dropped, caller's responsibility).
REQ-025 Redirect-to-decode latency SHALL be 2 edges: edge 1 loads pc=target and flushes IF/ID; edge 2 captures target instruction.
REQ-026 No combinational path SHALL exist from PCWrite/IFIDWrite/branch_taken to any output except through registers.

Reset
REQ-027 While reset=1 at an edge: pc=RESET_PC, ifid_instr=0, ifid_pc4=0, ifid_valid=0, stall_cnt=0, flush_cnt=0.
REQ-028 Reset SHALL override all other inputs, including a simultaneous branch_taken or stall.
REQ-029 First edge after reset deasserts SHALL capture instruction at RESET_PC with ifid_valid=1 (absent stall/flush).
REQ-030 Reset asserted mid-stall or mid-redirect SHALL discard that operation completely.

Configuration
REQ-031 Macro FETCH_STAGE_PERF_CNT_EN SHALL gate the performance counters.
REQ-032 Defined: stall_cnt increments on each edge with PCWrite==0 and branch_taken==0; flush_cnt increments on each edge with branch_taken==1; both saturate at 32'hFFFF_FFFF; both cleared by reset.
REQ-033 Undefined: stall_cnt and flush_cnt SHALL be constant 0, no counter flops; all other behaviour identical.

Verification
REQ-034 Reset 3 cycles, RESET_PC=0, no stall -> pc=0,4,8 on successive edges; ifid_pc4=4 with ifid_instr=mem[0], ifid_valid=1 one edge after reset release.
REQ-035 pc=0x10, PCWrite=0, IFIDWrite=0 for 2 cycles -> pc stays 0x10, IF/ID unchanged; stall_cnt=2 with macro, 0 without; resumes at 0x14.
REQ-036 pc=0x20, branch_taken=1, branch_target=0x103, PCWrite=0 same cycle -> pc=0x100, ifid_valid=0, ifid_instr=0; next edge ifid_pc4=0x104, valid=1; flush_cnt=1.
REQ-037 pc=32'hFFFF_FFFC, no stall -> next pc=0, ifid_pc4=0.
REQ-038 reset=1 in same cycle as branch_taken=1, target 0x200 -> pc=RESET_PC, ifid_valid=0, counters 0.
REQ-039 Macro defined, force counter to 32'hFFFF_FFFF via long stall -> further stall cycles leave stall_cnt at 32'hFFFF_FFFF.
